dly_tap_trainer: RTL

//  Calibration FSM that drives the 4-bit tap select of the 16-tap clock/data delay line.

---
 rtl/dly_tap_pkg.sv | 23 ++
 rtl/dly_window_tracker.sv | 65 ++++++
 rtl/dly_tap_trainer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dly_tap_pkg.sv
// Shared definitions for the delay-line tap trainer.
package dly_tap_pkg;

    localparam int unsigned TAP_W    = 4;
    localparam int unsigned NUM_TAPS = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        NEXT,
        FINISH
    } state_t;

    // Floor of the midpoint, using a TAP_W+1 bit sum so it cannot overflow.
    function automatic logic [TAP_W-1:0] tap_centre(input logic [TAP_W-1:0] lo,
                                                    input logic [TAP_W-1:0] hi);
        logic [TAP_W:0] sum;
        sum = {1'b0, lo} + {1'b0, hi};
        return sum[TAP_W:1];
    endfunction

endpackage

// File: rtl/dly_window_tracker.sv
// Tracks the longest contiguous run of passing taps.
// On a tie in run length, the earlier window is kept.
module dly_window_tracker
    import dly_tap_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             upd,
    input  logic             pass,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] best_lo,
    output logic [TAP_W-1:0] best_hi,
    output logic             any_pass
);

    logic             r_in_run;
    logic [TAP_W-1:0] r_run_lo;
    logic [TAP_W-1:0] r_best_lo;
    logic [TAP_W-1:0] r_best_hi;
    logic             r_any;

    logic [TAP_W-1:0] w_run_lo;
    logic [TAP_W:0]   w_run_len;
    logic [TAP_W:0]   w_best_len;

    always_comb begin
        w_run_lo   = r_in_run ? r_run_lo : tap;
        w_run_len  = {1'b0, tap} - {1'b0, w_run_lo} + (TAP_W+1)'(1);
        w_best_len = r_any ? ({1'b0, r_best_hi} - {1'b0, r_best_lo} + (TAP_W+1)'(1)) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_run  <= 1'b0;
            r_run_lo  <= '0;
            r_best_lo <= '0;
            r_best_hi <= '0;
            r_any     <= 1'b0;
        end else if (clear) begin
            r_in_run  <= 1'b0;
            r_run_lo  <= '0;
            r_best_lo <= '0;
            r_best_hi <= '0;
            r_any     <= 1'b0;
        end else if (upd) begin
            if (pass) begin
                r_in_run <= 1'b1;
                r_run_lo <= w_run_lo;
                r_any    <= 1'b1;
                if (w_run_len > w_best_len) begin
                    r_best_lo <= w_run_lo;
                    r_best_hi <= tap;
                end
            end else begin
                r_in_run <= 1'b0;
            end
        end
    end

    assign best_lo  = r_best_lo;
    assign best_hi  = r_best_hi;
    assign any_pass = r_any;

endmodule

// File: rtl/dly_tap_trainer.sv
// Sweeps the 16-tap delay line and parks dly_sel at the centre of the
// widest passing window reported by the downstream pattern checker.
module dly_tap_trainer
    import dly_tap_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 8,
    parameter int unsigned SAMPLES     = 16,
    parameter int unsigned DEFAULT_TAP = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sample_vld,
    input  logic             sample_ok,
    output logic [TAP_W-1:0] dly_sel,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [TAP_W-1:0] eye_lo,
    output logic [TAP_W-1:0] eye_hi
);

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0]       SAMPLE_LAST = 8'(SAMPLES - 1);
    localparam logic [TAP_W-1:0] DEF_TAP     = TAP_W'(DEFAULT_TAP);
    localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(NUM_TAPS - 1);

    state_t           r_state;
    logic [7:0]       r_settle_cnt;
    logic [7:0]       r_sample_cnt;
    logic             r_tap_fail;
    logic [TAP_W-1:0] r_dly_sel;
    logic             r_busy;
    logic             r_done;
    logic             r_fail;
    logic [TAP_W-1:0] r_eye_lo;
    logic [TAP_W-1:0] r_eye_hi;

    logic             w_clear;
    logic             w_upd;
    logic [TAP_W-1:0] w_best_lo;
    logic [TAP_W-1:0] w_best_hi;
    logic             w_any_pass;

    // Start is refused in the done/fail cycle even though the FSM is already in IDLE.
    assign w_clear = (r_state == IDLE) && start && !r_done && !r_fail;
    assign w_upd   = (r_state == NEXT);

    dly_window_tracker u_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_clear),
        .upd      (w_upd),
        .pass     (!r_tap_fail),
        .tap      (r_dly_sel),
        .best_lo  (w_best_lo),
        .best_hi  (w_best_hi),
        .any_pass (w_any_pass)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_settle_cnt <= '0;
            r_sample_cnt <= '0;
            r_tap_fail   <= 1'b0;
            r_dly_sel    <= DEF_TAP;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_eye_lo     <= '0;
            r_eye_hi     <= '0;
        end else begin
            r_done <= 1'b0;
            r_fail <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_clear) begin
                        r_dly_sel    <= '0;
                        r_settle_cnt <= '0;
                        r_sample_cnt <= '0;
                        r_tap_fail   <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_sample_cnt <= '0;
                        r_tap_fail   <= 1'b0;
                        r_state      <= SAMPLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 8'd1;
                    end
                end
                SAMPLE: begin
                    if (sample_vld) begin
                        r_sample_cnt <= r_sample_cnt + 8'd1;
                        if (!sample_ok) begin
                            r_tap_fail <= 1'b1;
                        end
                        if (r_sample_cnt == SAMPLE_LAST) begin
                            r_state <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (r_dly_sel == LAST_TAP) begin
                        r_state <= FINISH;
                    end else begin
                        r_dly_sel    <= r_dly_sel + TAP_W'(1);
                        r_settle_cnt <= '0;
                        r_state      <= SETTLE;
                    end
                end
                FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                    if (w_any_pass) begin
                        r_eye_lo  <= w_best_lo;
                        r_eye_hi  <= w_best_hi;
                        r_dly_sel <= tap_centre(w_best_lo, w_best_hi);
                        r_done    <= 1'b1;
                    end else begin
                        r_dly_sel <= DEF_TAP;
                        r_fail    <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dly_sel = r_dly_sel;
    assign busy    = r_busy;
    assign done    = r_done;
    assign fail    = r_fail;
    assign eye_lo  = r_eye_lo;
    assign eye_hi  = r_eye_hi;

endmodule
